// File: rtl/fifo_share_ctrl_if.sv
// Producer, FIFO-port and consumer signals of the shared-FIFO controller.
// "slave" is the controller's view; "master" is the surrounding logic that drives it.
interface fifo_share_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  fifo_write;
    logic [WIDTH-1:0]      fifo_wdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_read;
    logic [WIDTH-1:0]      fifo_rdata;
    logic                  rd_valid;
    logic [WIDTH-1:0]      rd_data;
    logic                  rd_ready;

    modport master (
        output req, req_data, fifo_full, fifo_empty, fifo_rdata, rd_ready,
        input  ack, fifo_write, fifo_wdata, fifo_read, rd_valid, rd_data
    );

    modport slave (
        input  req, req_data, fifo_full, fifo_empty, fifo_rdata, rd_ready,
        output ack, fifo_write, fifo_wdata, fifo_read, rd_valid, rd_data
    );
endinterface

// File: rtl/fifo_share_ctrl.sv
// Round-robin write arbiter plus pop/hold read sequencer around a RAM FIFO.
// Writes are same-cycle and stall on full; reads surface RD_LAT+1 cycles after the pop and hold until rd_ready.
module fifo_share_ctrl #(
    parameter int WIDTH  = 4,
    parameter int NREQ   = 2,
    parameter int RD_LAT = 1
) (
    input logic          clk,
    input logic          reset,
    fifo_share_ctrl_if.slave bus
);
    localparam int GW = $clog2(NREQ);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} rd_state_t;

    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    grant_idx;
    logic             grant_found;
    logic             wr_en;
    rd_state_t        rd_state;
    logic [LW-1:0]    lat_cnt;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_data_q;

    // Search starts one past the last winner so every producer gets a turn.
    always_comb begin
        logic [GW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = last_grant;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NREQ);
            if (!grant_found && bus.req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign wr_en          = grant_found & ~bus.fifo_full & reset;
    assign bus.fifo_write = wr_en;
    assign bus.ack        = wr_en ? (NREQ'(1) << grant_idx) : '0;
    assign bus.fifo_wdata = wr_en ? bus.req_data[int'(grant_idx)*WIDTH +: WIDTH] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GW'(NREQ - 1);
        end else if (wr_en) begin
            last_grant <= grant_idx;
        end
    end

    // The pop strobe must fall in the IDLE cycle itself to meet the RD_LAT timing.
    assign bus.fifo_read = (rd_state == IDLE) & ~bus.fifo_empty & reset;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_state   <= IDLE;
            lat_cnt    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            case (rd_state)
                IDLE: begin
                    if (!bus.fifo_empty) begin
                        lat_cnt  <= LW'(RD_LAT - 1);
                        rd_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end else begin
                        rd_data_q  <= bus.fifo_rdata;
                        rd_valid_q <= 1'b1;
                        rd_state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        rd_state   <= IDLE;
                    end
                end
                default: rd_state <= IDLE;
            endcase
        end
    end
endmodule
